// File: rtl/scan_line_controller_if.sv
// Serialized sample stream toward the line buffer: one channel word per
// valid/ready handshake.
interface scan_line_controller_if #(
   parameter int DW = 12
);
   logic [DW-1:0] out_data;
   logic [2:0]    out_ch;
   logic          out_last;
   logic          out_valid;
   logic          out_ready;

   modport master (
      output out_data, out_ch, out_last, out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data, out_ch, out_last, out_valid,
      output out_ready
   );
endinterface

// File: rtl/scan_line_controller.sv
// Ultrasound scan-line acquisition sequencer: trigger, dead time, capture of
// LINE_LEN 8-channel vectors, serialization of enabled channels onto a stream.
// Optional macro SCAN_CTRL_TESTPAT_EN replaces ADC data with a synthetic pattern.
module scan_line_controller #(
   parameter int DW       = 12,
   parameter int LINE_LEN = 1024,
   parameter int CNT_W    = 11
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  trig_in,
   input  logic [15:0]           delay_cycles,
   input  logic [7:0]            ch_mask,
   input  logic                  adc_strb,
   input  logic [DW-1:0]         data_a,
   input  logic [DW-1:0]         data_b,
   input  logic [DW-1:0]         data_c,
   input  logic [DW-1:0]         data_d,
   input  logic [DW-1:0]         data_e,
   input  logic [DW-1:0]         data_f,
   input  logic [DW-1:0]         data_g,
   input  logic [DW-1:0]         data_h,
   scan_line_controller_if.master out_if,
   output logic                  busy,
   output logic                  line_done,
   output logic                  overrun,
   output logic                  trig_miss,
   output logic [CNT_W-1:0]      vec_cnt
);

   typedef enum logic [1:0] {IDLE, DELAY, ACQ, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [15:0]      dly_q, dly_d;
   logic [7:0]       mask_q, mask_d;
   logic [7:0]       rem_q, rem_d;
   logic [DW-1:0]    hold_q [8];
   logic [DW-1:0]    hold_d [8];
   logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
   logic             overrun_q, overrun_d;
   logic             trig_miss_q, trig_miss_d;
   logic             line_done_q, line_done_d;
   logic             last_vec_q, last_vec_d;

   logic [DW-1:0]    src [8];
   logic [2:0]       idx;
   logic [7:0]       lowbit;
   logic             found;
   logic             out_valid;
   logic             hs;
   logic [7:0]       rem_pop;
   logic             capture;

   always_comb begin
`ifdef SCAN_CTRL_TESTPAT_EN
      logic [31:0] vc_ext;
      vc_ext = 32'(vec_cnt_q);
      for (int unsigned i = 0; i < 8; i++) begin
         src[i] = {3'(i), vc_ext[DW-4:0]};
      end
`else
      src[0] = data_a;
      src[1] = data_b;
      src[2] = data_c;
      src[3] = data_d;
      src[4] = data_e;
      src[5] = data_f;
      src[6] = data_g;
      src[7] = data_h;
`endif
   end

   // Serializer: lowest pending channel is presented; the word held in the
   // register counts as gone once its handshake happens this cycle.
   always_comb begin
      idx   = 3'd0;
      found = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (rem_q[i] && !found) begin
            idx   = 3'(i);
            found = 1'b1;
         end
      end
      lowbit    = 8'd1 << idx;
      out_valid = |rem_q;
      hs        = out_valid & out_if.out_ready;
      rem_pop   = hs ? (rem_q & ~lowbit) : rem_q;
   end

   always_comb begin
      state_d     = state_q;
      dly_d       = dly_q;
      mask_d      = mask_q;
      rem_d       = rem_pop;
      vec_cnt_d   = vec_cnt_q;
      overrun_d   = overrun_q;
      trig_miss_d = trig_miss_q;
      line_done_d = 1'b0;
      last_vec_d  = last_vec_q;
      capture     = 1'b0;

      case (state_q)
         IDLE: begin
            if (trig_in) begin
               dly_d       = delay_cycles;
               mask_d      = ch_mask;
               vec_cnt_d   = '0;
               overrun_d   = 1'b0;
               trig_miss_d = 1'b0;
               last_vec_d  = 1'b0;
               state_d     = (delay_cycles == 16'd0) ? ACQ : DELAY;
            end
         end
         DELAY: begin
            dly_d = dly_q - 16'd1;
            if (dly_q == 16'd1) state_d = ACQ;
         end
         ACQ: begin
            if (adc_strb) begin
               if (rem_pop == 8'd0) begin
                  capture   = 1'b1;
                  rem_d     = mask_q;
                  vec_cnt_d = vec_cnt_q + CNT_W'(1);
                  if (vec_cnt_q == CNT_W'(LINE_LEN - 1)) begin
                     last_vec_d = 1'b1;
                     // An empty mask leaves nothing to drain, so finish now.
                     if (mask_q == 8'd0) begin
                        state_d     = IDLE;
                        line_done_d = 1'b1;
                     end else begin
                        state_d = DRAIN;
                     end
                  end
               end else begin
                  overrun_d = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (rem_pop == 8'd0) begin
               state_d     = IDLE;
               line_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (trig_in && state_q != IDLE) trig_miss_d = 1'b1;

      for (int unsigned i = 0; i < 8; i++) begin
         hold_d[i] = capture ? src[i] : hold_q[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         dly_q       <= '0;
         mask_q      <= '0;
         rem_q       <= '0;
         vec_cnt_q   <= '0;
         overrun_q   <= 1'b0;
         trig_miss_q <= 1'b0;
         line_done_q <= 1'b0;
         last_vec_q  <= 1'b0;
         for (int unsigned i = 0; i < 8; i++) hold_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         dly_q       <= dly_d;
         mask_q      <= mask_d;
         rem_q       <= rem_d;
         vec_cnt_q   <= vec_cnt_d;
         overrun_q   <= overrun_d;
         trig_miss_q <= trig_miss_d;
         line_done_q <= line_done_d;
         last_vec_q  <= last_vec_d;
         for (int unsigned i = 0; i < 8; i++) hold_q[i] <= hold_d[i];
      end
   end

   assign out_if.out_valid = out_valid;
   assign out_if.out_data  = hold_q[idx];
   assign out_if.out_ch    = idx;
   assign out_if.out_last  = last_vec_q & out_valid & ((rem_q & ~lowbit) == 8'd0);

   assign busy      = (state_q != IDLE);
   assign line_done = line_done_q;
   assign overrun   = overrun_q;
   assign trig_miss = trig_miss_q;
   assign vec_cnt   = vec_cnt_q;

endmodule
